// File: rtl/vector_fifo_packer.sv
// rtl/vector_fifo_packer.sv - packs a scalar sample stream into WIDTH_VECTOR-lane vectors for a FIFO write port
//
// Ports:
//   clk, rstn              write clock, asynchronous active-low reset
//   s_valid/s_ready        sample handshake; s_data is lane data, s_last closes the vector early
//   fifo_full              FIFO full flag (same clock domain)
//   fifo_winc, fifo_wdata  one-cycle write strobe and packed vector (lane k at [k*N +: N])
//   busy                   partial vector in progress or output register occupied
//   vec_count, pad_count   wrapping counts of vectors written / vectors flushed short
module vector_fifo_packer #(
    parameter int              WIDTH_VECTOR = 8,
    parameter int              N            = 32,
    parameter int              CNT_W        = 16,
    parameter logic [N-1:0]    PAD_VALUE    = '0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [N-1:0]              s_data,
    input  logic                      s_last,
    input  logic                      fifo_full,
    output logic                      fifo_winc,
    output logic [WIDTH_VECTOR*N-1:0] fifo_wdata,
    output logic                      busy,
    output logic [CNT_W-1:0]          vec_count,
    output logic [CNT_W-1:0]          pad_count
);

    localparam int LANE_W = $clog2(WIDTH_VECTOR);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WIDTH_VECTOR - 1);

    logic [LANE_W-1:0]          lane_cnt;
    logic [WIDTH_VECTOR*N-1:0]  pack_q;
    logic [WIDTH_VECTOR*N-1:0]  out_q;
    logic                       out_valid;
    logic [WIDTH_VECTOR*N-1:0]  next_vec;
    logic                       accept;
    logic                       last_lane;
    logic                       complete;

    // The output register is either empty or being written this cycle, so a
    // new complete vector always has somewhere to go when s_ready is high.
    assign s_ready   = ~out_valid | ~fifo_full;
    assign accept    = s_valid & s_ready;
    assign last_lane = (lane_cnt == LAST_LANE);
    assign complete  = accept & (last_lane | s_last);
    assign fifo_winc = out_valid & ~fifo_full;
    assign fifo_wdata = out_q;
    assign busy      = (lane_cnt != '0) | out_valid;

    // Vector as it would look if the current beat closed it: lanes already
    // gathered, the incoming beat, then padding. Padding is applied here
    // explicitly so a non-zero PAD_VALUE is honoured even straight after reset.
    always_comb begin
        next_vec = '0;
        for (int k = 0; k < WIDTH_VECTOR; k++) begin
            if (k < int'(lane_cnt)) begin
                next_vec[k*N +: N] = pack_q[k*N +: N];
            end else if (k == int'(lane_cnt)) begin
                next_vec[k*N +: N] = s_data;
            end else begin
                next_vec[k*N +: N] = PAD_VALUE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane_cnt  <= '0;
            pack_q    <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
            vec_count <= '0;
            pad_count <= '0;
        end else begin
            if (complete) begin
                out_q     <= next_vec;
                out_valid <= 1'b1;
                lane_cnt  <= '0;
                pack_q    <= {WIDTH_VECTOR{PAD_VALUE}};
                if (s_last && !last_lane) begin
                    pad_count <= pad_count + CNT_W'(1);
                end
            end else begin
                if (fifo_winc) begin
                    out_valid <= 1'b0;
                end
                if (accept) begin
                    for (int k = 0; k < WIDTH_VECTOR; k++) begin
                        if (k == int'(lane_cnt)) begin
                            pack_q[k*N +: N] <= s_data;
                        end
                    end
                    lane_cnt <= lane_cnt + LANE_W'(1);
                end
            end
            if (fifo_winc) begin
                vec_count <= vec_count + CNT_W'(1);
            end
        end
    end

endmodule
